// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: MEM-stage data port bundle between the pipeline (master)
// and the data memory responder (slave).
interface data_mem_if;
    logic        read;
    logic        write;
    logic [15:0] address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        ready;
    logic        addr_err;

    modport master (
        output read, write, address, writedata,
        input  readdata, ready, addr_err
    );

    modport slave (
        input  read, write, address, writedata,
        output readdata, ready, addr_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: slow-SRAM emulation for the MEM-stage data port.
// Every access takes WAIT_CYCLES+1 cycles; ready drops to freeze the pipeline.
// Optional build macro DMEM_ACCESS_COUNT_EN adds rd_count/wr_count access counters.
module data_mem_responder #(
    parameter int unsigned DEPTH_LOG2  = 6,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned BASE_ADDR   = 1024
) (
    input  logic             clk,
    input  logic             rst,      // asynchronous, active-low
    data_mem_if.slave        bus
`ifdef DMEM_ACCESS_COUNT_EN
    ,
    output logic [15:0]      rd_count,
    output logic [15:0]      wr_count
`endif
);

    localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    op_wr_q, op_wr_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic                    inr_q, inr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             readdata_q, readdata_d;
    logic                    err_q, err_d;

    logic                    req;
    logic [15:0]             rel;
    logic [13:0]             idx_full;
    logic                    in_range;

    logic                    acc_en;
    logic                    acc_wr;
    logic                    acc_inr;
    logic [DEPTH_LOG2-1:0]   acc_idx;
    logic [31:0]             acc_wdata;
    logic                    mem_we;

    logic [31:0]             mem [DEPTH] = '{default: '0};

    // Address decode: 16-bit wrapping offset from base, range check on the full word index
    always_comb begin
        req      = bus.read | bus.write;
        rel      = bus.address - 16'(BASE_ADDR);
        idx_full = 14'(rel >> 2);
        in_range = (32'(idx_full) < 32'(DEPTH));
    end

    // Next-state and access control; with zero wait the access is taken straight from the bus
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_wr_d   = op_wr_q;
        idx_d     = idx_q;
        inr_d     = inr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        acc_en    = 1'b0;
        acc_wr    = op_wr_q;
        acc_inr   = inr_q;
        acc_idx   = idx_q;
        acc_wdata = wdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    op_wr_d = bus.write;
                    idx_d   = idx_full[DEPTH_LOG2-1:0];
                    inr_d   = in_range;
                    wdata_d = bus.writedata;
                    err_d   = ~in_range;
                    if (WAIT_CYCLES == 0) begin
                        acc_en    = 1'b1;
                        acc_wr    = bus.write;
                        acc_inr   = in_range;
                        acc_idx   = idx_full[DEPTH_LOG2-1:0];
                        acc_wdata = bus.writedata;
                        state_d   = DONE;
                    end else begin
                        cnt_d   = WAIT_INIT;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (!req) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    acc_en  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Access datapath: write wins over read; out-of-range reads return zero
    always_comb begin
        mem_we     = acc_en & acc_wr & acc_inr;
        readdata_d = readdata_q;
        if (acc_en && !acc_wr) begin
            readdata_d = acc_inr ? mem[acc_idx] : '0;
        end
    end

    // Control and read-data registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_wr_q    <= 1'b0;
            idx_q      <= '0;
            inr_q      <= 1'b0;
            wdata_q    <= '0;
            readdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_wr_q    <= op_wr_d;
            idx_q      <= idx_d;
            inr_q      <= inr_d;
            wdata_q    <= wdata_d;
            readdata_q <= readdata_d;
            err_q      <= err_d;
        end
    end

    // Memory array: not touched by reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    assign bus.readdata = readdata_q;
    assign bus.ready    = ((state_q == IDLE) && !req) || (state_q == DONE);
    assign bus.addr_err = (state_q == DONE) && err_q;

`ifdef DMEM_ACCESS_COUNT_EN
    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] wr_count_q, wr_count_d;

    // Count in-range accesses in the cycle they are performed
    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (acc_en && acc_inr) begin
            if (acc_wr) wr_count_d = wr_count_q + 16'd1;
            else        rd_count_d = rd_count_q + 16'd1;
        end
    end

    // Access counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed bench with scoreboard for data_mem_responder.
// Unit A uses WAIT_CYCLES=2, unit B uses WAIT_CYCLES=0.
module tb_data_mem_responder;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    data_mem_if bus_a ();
    data_mem_if bus_b ();

`ifdef DMEM_ACCESS_COUNT_EN
    logic [15:0] rd_count_a, wr_count_a, rd_count_b, wr_count_b;
`endif

    data_mem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(2), .BASE_ADDR(1024)) u_dut_a (
        .clk      (clk),
        .rst      (rst_n),
        .bus      (bus_a.slave)
`ifdef DMEM_ACCESS_COUNT_EN
        ,
        .rd_count (rd_count_a),
        .wr_count (wr_count_a)
`endif
    );

    data_mem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(0), .BASE_ADDR(1024)) u_dut_b (
        .clk      (clk),
        .rst      (rst_n),
        .bus      (bus_b.slave)
`ifdef DMEM_ACCESS_COUNT_EN
        ,
        .rd_count (rd_count_b),
        .wr_count (wr_count_b)
`endif
    );

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
        int          low;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_mem [64];
    logic [31:0] model_rdata;
    int          tests_run    = 0;
    int          tests_failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one request on unit A, model it, wait for DONE and compare with the scoreboard
    task automatic access_a(input string tag, input logic rd, input logic wr,
                            input logic [15:0] addr, input logic [31:0] data);
        logic [15:0] rel;
        logic [13:0] idx;
        logic        inr;
        exp_t        e;
        int          low;
        int          guard;
        rel = addr - 16'd1024;
        idx = 14'(rel >> 2);
        inr = (idx < 14'd64);
        if (wr) begin
            if (inr) model_mem[idx[5:0]] = data;
        end else if (rd) begin
            model_rdata = inr ? model_mem[idx[5:0]] : 32'h0;
        end
        e.tag = tag; e.rdata = model_rdata; e.err = ~inr; e.low = 3;
        sb.push_back(e);

        @(negedge clk);
        bus_a.read = rd; bus_a.write = wr; bus_a.address = addr; bus_a.writedata = data;
        #1;
        low = 0; guard = 0;
        while (!bus_a.ready && guard < 50) begin
            low++;
            @(negedge clk); #1;
            guard++;
        end
        if (guard >= 50) chk({tag, "_timeout"}, 32'(bus_a.ready), 32'd1);
        e = sb.pop_front();
        chk({e.tag, "_rdata"}, bus_a.readdata, e.rdata);
        chk({e.tag, "_err"},   32'(bus_a.addr_err), 32'(e.err));
        chk({e.tag, "_stall"}, 32'(low), 32'(e.low));
        @(negedge clk);
        bus_a.read = 1'b0; bus_a.write = 1'b0;
    endtask

    // Unit B write used only to set up known contents
    task automatic write_b(input logic [15:0] addr, input logic [31:0] data);
        int guard;
        @(negedge clk);
        bus_b.write = 1'b1; bus_b.address = addr; bus_b.writedata = data;
        #1;
        guard = 0;
        while (!bus_b.ready && guard < 50) begin
            @(negedge clk); #1;
            guard++;
        end
        if (guard >= 50) chk("b_write_timeout", 32'(bus_b.ready), 32'd1);
        @(negedge clk);
        bus_b.write = 1'b0;
    endtask

    initial begin
        logic [15:0] rd_base, wr_base;
        for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;
        model_rdata = 32'h0;
        bus_a.read = 0; bus_a.write = 0; bus_a.address = '0; bus_a.writedata = '0;
        bus_b.read = 0; bus_b.write = 0; bus_b.address = '0; bus_b.writedata = '0;
        rd_base = '0; wr_base = '0;

        // Reset state
        #12;
        chk("rst_ready",    32'(bus_a.ready),    32'd1);
        chk("rst_readdata", bus_a.readdata,      32'h0);
        chk("rst_addr_err", 32'(bus_a.addr_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write then read, three-cycle stall each
        access_a("wr_1024", 1'b0, 1'b1, 16'd1024, 32'hDEADBEEF);
        access_a("rd_1024", 1'b1, 1'b0, 16'd1024, 32'h0);

        // Byte offset bits ignored
        access_a("wr_1028", 1'b0, 1'b1, 16'd1028, 32'h12345678);
        access_a("rd_1031", 1'b1, 1'b0, 16'd1031, 32'h0);

        // Out of range: above the array and below the base
        access_a("wr_oor",  1'b0, 1'b1, 16'd1280, 32'hAAAA5555);
        access_a("rd_1024b",1'b1, 1'b0, 16'd1024, 32'h0);
        access_a("rd_1000", 1'b1, 1'b0, 16'd1000, 32'h0);
        access_a("rd_1024c",1'b1, 1'b0, 16'd1024, 32'h0);

        // Read and write together: write wins, readdata untouched
        access_a("rdwr_1032", 1'b1, 1'b1, 16'd1032, 32'd5);
        access_a("rd_1032",   1'b1, 1'b0, 16'd1032, 32'h0);

        // Abort and reset in the middle of writes
        access_a("wr_1036", 1'b0, 1'b1, 16'd1036, 32'h11);
        access_a("wr_1040", 1'b0, 1'b1, 16'd1040, 32'h22);

        @(negedge clk);
        bus_a.write = 1'b1; bus_a.address = 16'd1036; bus_a.writedata = 32'h99;
        @(negedge clk); #1;
        chk("abort_busy_ready", 32'(bus_a.ready), 32'd0);
        bus_a.write = 1'b0;
        @(negedge clk); #1;
        chk("abort_idle_ready", 32'(bus_a.ready), 32'd1);

        @(negedge clk);
        bus_a.write = 1'b1; bus_a.address = 16'd1040; bus_a.writedata = 32'h77;
        @(negedge clk); #1;
        rst_n = 1'b0;
        bus_a.write = 1'b0;
        #1;
        chk("midrst_ready",    32'(bus_a.ready),    32'd1);
        chk("midrst_readdata", bus_a.readdata,      32'h0);
        chk("midrst_addr_err", 32'(bus_a.addr_err), 32'd0);
        model_rdata = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;

        access_a("rd_1036", 1'b1, 1'b0, 16'd1036, 32'h0);
        access_a("rd_1040", 1'b1, 1'b0, 16'd1040, 32'h0);

        // Unit B: zero wait, back-to-back reads
        write_b(16'd1024, 32'h0000000A);
        write_b(16'd1028, 32'h0000000B);
`ifdef DMEM_ACCESS_COUNT_EN
        rd_base = rd_count_b;
        wr_base = wr_count_b;
`endif
        @(negedge clk);
        bus_b.read = 1'b1; bus_b.address = 16'd1024;
        #1;
        chk("b_ready0", 32'(bus_b.ready), 32'd0);
        @(negedge clk); #1;
        chk("b_ready1", 32'(bus_b.ready), 32'd1);
        chk("b_rd1024", bus_b.readdata,   32'h0000000A);
        bus_b.address = 16'd1028;
        @(negedge clk); #1;
        chk("b_ready2", 32'(bus_b.ready), 32'd0);
        @(negedge clk); #1;
        chk("b_ready3", 32'(bus_b.ready), 32'd1);
        chk("b_rd1028", bus_b.readdata,   32'h0000000B);
        bus_b.read = 1'b0;
        @(negedge clk); #1;
`ifdef DMEM_ACCESS_COUNT_EN
        chk("b_rd_count", 32'(rd_count_b), 32'(rd_base + 16'd2));
        chk("b_wr_count", 32'(wr_count_b), 32'(wr_base));
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
